imem_loader: RTL

//  Write side of the instruction memory. Receives a byte stream over a valid/ready

---
 rtl/loader_pkg.sv | 26 ++
 rtl/byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM states (length bytes, data, checksum, done, error)
//   CNT_W          : width of the little-endian word-count field in a frame
//   accepts_bytes(): 1 for the states in which the loader takes stream bytes
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // DONE and ERR wait for a new start pulse; every other state consumes bytes.
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects four consecutive bytes into one little-endian 32-bit word.
// The first byte of a word lands in [7:0], the fourth in [31:24].
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       synchronous reset, active-low
//   i_clear       return to lane 0 (used whenever the loader is not in DATA)
//   i_byte_en     a byte is accepted this cycle
//   i_byte        the accepted byte
//   o_word_valid  combinational: the accepted byte completes a word
//   o_word        combinational: the completed word (valid with o_word_valid)
// ---------------------------------------------------------------------------
module byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;

    // Lanes 0..2 are stored; the fourth byte is passed straight into the word so
    // the completed word is available on the same edge that accepts it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
                2'd0:    r_shift[7:0]   <= i_byte;
                2'd1:    r_shift[15:8]  <= i_byte;
                2'd2:    r_shift[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

    assign o_word_valid = i_byte_en && (r_lane == 2'd3);
    assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Write side of the instruction memory. A byte stream (valid/ready) carries a
// 16-bit little-endian word count N followed by 4*N data bytes. Bytes are packed
// into little-endian words and written to addresses 0..N-1 while the CPU is held.
// o_cpu_run rises once the whole image is in memory.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the frame; it must equal the XOR of all
//   preceding frame bytes (both count bytes included). A mismatch ends in ERR.
//
// Parameters:
//   DEPTH   instruction-memory size in 32-bit words
//   ADDR_W  word-address width, equal to clog2(DEPTH)
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       synchronous reset, active-low
//   i_start       1-cycle pulse; leaves DONE/ERR and begins a new load
//   i_byte_valid  source presents a byte
//   i_byte_data   stream byte
//   o_byte_ready  loader accepts a byte this cycle
//   o_imem_we     instruction-memory write strobe, one cycle per word
//   o_imem_addr   word address
//   o_imem_wdata  packed word
//   o_cpu_run     image valid, CPU may run
//   o_load_err    sticky error flag, cleared by start or reset
// ---------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_run,
    output logic              o_load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_FRAME_END = ST_CHK;
`else
    localparam state_t ST_FRAME_END = ST_DONE;
`endif

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_cnt_lo;
    logic [CNT_W-1:0]   r_word_total;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic               r_cpu_run;
    logic               r_load_err;

    logic               w_byte_ready;
    logic               w_accept;
    logic               w_data_en;
    logic [CNT_W-1:0]   w_count;
    logic               w_word_valid;
    logic [31:0]        w_word;
    logic               w_last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         r_chk;
`endif

    assign w_byte_ready = accepts_bytes(r_state);
    assign w_accept     = i_byte_valid && w_byte_ready;
    assign w_data_en    = w_accept && (r_state == ST_DATA);
    assign w_count      = {i_byte_data, r_cnt_lo};
    assign w_last_word  = w_word_valid && (r_word_cnt == (r_word_total - CNT_W'(1)));

    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (r_state != ST_DATA),
        .i_byte_en    (w_data_en),
        .i_byte       (i_byte_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Oversized counts are rejected as soon as the high count byte arrives, so
    // the address counter can never run past the end of memory.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LEN0: begin
                if (w_accept) w_next_state = ST_LEN1;
            end
            ST_LEN1: begin
                if (w_accept) begin
                    if (w_count == '0)
                        w_next_state = ST_FRAME_END;
                    else if (w_count > CNT_W'(DEPTH))
                        w_next_state = ST_ERR;
                    else
                        w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_last_word) w_next_state = ST_FRAME_END;
            end
            ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_accept)
                    w_next_state = (i_byte_data == r_chk) ? ST_DONE : ST_ERR;
`else
                w_next_state = ST_LEN0;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (i_start) w_next_state = ST_LEN0;
            end
            default: w_next_state = ST_LEN0;
        endcase
    end

    // Write port is registered: the strobe appears the cycle after the fourth
    // byte of a word is accepted. Address/data only move when a word is written.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_LEN0;
            r_cnt_lo     <= '0;
            r_word_total <= '0;
            r_word_cnt   <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_run    <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_imem_we <= w_word_valid;
            if (w_accept && (r_state == ST_LEN0)) begin
                r_cnt_lo   <= i_byte_data;
                r_word_cnt <= '0;
            end else if (w_word_valid) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_accept && (r_state == ST_LEN1))
                r_word_total <= w_count;
            if (w_word_valid) begin
                r_imem_addr  <= r_word_cnt[ADDR_W-1:0];
                r_imem_wdata <= w_word;
            end
            // Registered from the current state, so run follows DONE by a cycle
            // and a start pulse in DONE drops it on the very next edge.
            r_cpu_run  <= (r_state == ST_DONE) && !i_start;
            r_load_err <= (w_next_state == ST_ERR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over the frame; the first count byte restarts it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_chk <= '0;
        end else if (w_accept) begin
            if (r_state == ST_LEN0)
                r_chk <= i_byte_data;
            else
                r_chk <= r_chk ^ i_byte_data;
        end
    end
`endif

    assign o_byte_ready = w_byte_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_cpu_run    = r_cpu_run;
    assign o_load_err   = r_load_err;

endmodule
